// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the sequenced multi-mode shift register.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ASR  = 3'b101
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Effective step count: never more steps than there are bit positions.
  function automatic logic [31:0] clamp_amount(input logic [31:0] amount,
                                               input logic [31:0] width);
    return (amount > width) ? width : amount;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter shared by every shift/rotate step.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHR: begin
        next_q  = {ser_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_SHL: begin
        next_q  = {q[WIDTH-2:0], ser_in};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Multi-mode shift register performing one bit-position per clock, with
// serial I/O and a busy/done handshake.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  logic [31:0]      n_eff;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign op_in   = op_e'(op);
  assign n_eff   = clamp_amount(32'(amount), 32'(WIDTH));
  // The start-cycle step uses the live op; SHIFT steps use the latched one.
  assign step_op = (state_q == IDLE) ? op_in : op_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .op      (step_op),
    .ser_in  (ser_in),
    .next_q  (step_q),
    .out_bit (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_in)
            OP_LOAD: begin
              q_d    = load_data;
              done_d = 1'b1;
            end
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: begin
              if (n_eff == 32'd0) begin
                done_d = 1'b1;
              end else begin
                q_d       = step_q;
                ser_out_d = step_bit;
                if (n_eff == 32'd1) begin
                  done_d = 1'b1;
                end else begin
                  op_d    = op_in;
                  cnt_d   = AW'(n_eff - 32'd1);
                  state_d = SHIFT;
                  busy_d  = 1'b1;
                end
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        q_d       = step_q;
        ser_out_d = step_bit;
        cnt_d     = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised multi-mode shift register with a sequenced, multi-cycle shift engine.
- Accepts one command at a time (parallel load, or shift/rotate by a programmable amount) and performs one bit-position per clock.
- Provides serial in/out, plus busy/done status for an upstream controller.
- Successor to the fixed 8-bit logical-right shifter: adds generic width, left/rotate/arithmetic modes, arbitrary amount, serial I/O and a handshake.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AW, 4, width of amount input; must satisfy 2**AW-1 >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe, sampled only when busy=0.
- op  input  3  command: 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 ASR, 110/111 reserved.
- amount  input  AW  shift count, sampled with start; ignored for LOAD.
- load_data  input  WIDTH  parallel load value.
- ser_in  input  1  fill bit for SHR (into MSB) and SHL (into LSB); sampled live on every shift edge.
- q  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted or rotated out.
- busy  output  1  command in progress; start ignored while high.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): q=0, ser_out=0, busy=0, done=0, state=IDLE, counter=0. Takes effect immediately, including mid-command; the command in flight is discarded.
- FSM states: IDLE, SHIFT.
- done defaults to 0 every cycle and is high for exactly one cycle after the completing edge.
- Clamping: effective count N = min(amount, WIDTH).
- start=1 in IDLE at edge k:
  - LOAD: q<=load_data at edge k; done=1 after edge k; ser_out unchanged.
  - Shift op with N=0, or reserved op: q and ser_out unchanged; done=1 after edge k; no SHIFT entry.
  - Shift op with N=1: one step at edge k; done=1 after edge k; stays IDLE.
  - Shift op with N>=2: one step at edge k; latch op; counter<=N-1; go to SHIFT with busy=1.
- SHIFT state:
  - One step per edge and counter decrements.
  - At the edge where counter goes 1->0: perform the final step, go to IDLE, busy<=0, done<=1.
  - Total: N steps at edges k..k+N-1; done high in the cycle after edge k+N-1; busy high for N-1 cycles.
- Step definitions (one position):
  - SHR: q<={ser_in,q[W-1:1]}, ser_out<=q[0].
  - SHL: q<={q[W-2:0],ser_in}, ser_out<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}, ser_out<=q[0].
  - ROL: q<={q[W-2:0],q[W-1]}, ser_out<=q[W-1].
  - ASR: q<={q[W-1],q[W-1:1]}, ser_out<=q[0].
- start while busy=1: ignored entirely; op, amount and load_data are not captured.
- start on the same cycle done is high: busy is already 0, so the command is accepted (back-to-back issue allowed).
- op, amount and load_data only need to be valid in the start cycle.

Decomposition:
- Package shift_reg_pkg:
  - op_e enum (LOAD, SHR, SHL, ROR, ROL, ASR).
  - state_e enum (IDLE, SHIFT).
  - Function clamp_amount.
- One natural sub-module, shift_step: purely combinational single-position shifter taking q, op and ser_in, producing next_q and out_bit. It is instantiated once and shared by the start-cycle step and the SHIFT-state step.

Test Plan (WIDTH=8, AW=4):
- Reset: rst_n=0 mid-SHIFT (after LOAD 0xFF, ROR amount 5, 2 edges) -> immediately q=0x00, busy=0, done=0, ser_out=0; start after release behaves normally.
- Load plus logical shift: LOAD 0xB4 -> q=0xB4, done 1 cycle. SHR amount 3, ser_in=0 -> busy 2 cycles, q=0x16, ser_out=1, done 1 cycle.
- Arithmetic and rotate:
  - LOAD 0x96, ASR amount 2 -> q=0xE5, ser_out=1.
  - LOAD 0x81, ROL amount 1 -> q=0x03 and done after the same edge with busy never high.
- Clamp and serial fill: LOAD 0x00, SHL amount 12, ser_in=1 -> exactly 8 steps, q=0xFF, ser_out=0, done in the cycle after the 8th edge.
- Ignored start and back-to-back issue:
  - During SHR amount 4, pulse start with LOAD 0xAA -> ignored, final q matches a 4-step shift.
  - start LOAD 0x5A in the done cycle -> accepted, q=0x5A next edge.
- Null commands: SHR amount 0, and op=110 -> q unchanged, done pulses once, busy stays 0.
